// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch stage: owns the PC, reads 16-bit opcodes, and hands them to decode
// over a valid/ready handshake. Optional macro FETCH_ALIGN_CHK_EN enables the misaligned-PC fault.
module chip8_fetch #(
    parameter int unsigned           ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]     START_ADDR = ADDR_W'('h200)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              pc_skip,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_CAPTURE = 3'd2,
        S_VALID   = 3'd3,
        S_FAULT   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              fetch_go_c;
    logic [ADDR_W-1:0] pc_plus2_c;

    assign pc_plus2_c = pc_q + ADDR_W'(2);

    // Next-state: a redirect overrides everything; fetch_go_c marks every entry into ADDR.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fetch_go_c = 1'b0;

        if (pc_load && (state_q != S_FAULT)) begin
            pc_d       = pc_load_val;
            valid_d    = 1'b0;
            state_d    = S_IDLE;
            fetch_go_c = run;
        end else begin
            case (state_q)
                S_IDLE:    fetch_go_c = run;
                S_ADDR:    state_d = S_CAPTURE;
                S_CAPTURE: begin
                    instr_d    = mem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_plus2_c;
                    valid_d    = 1'b1;
                    state_d    = S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        valid_d    = 1'b0;
                        state_d    = S_IDLE;
                        fetch_go_c = run;
                        if (pc_skip) begin
                            pc_d = pc_plus2_c;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end

        if (fetch_go_c) begin
            state_d = S_ADDR;
`ifdef FETCH_ALIGN_CHK_EN
            if (pc_d[0]) begin
                state_d = S_FAULT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= START_ADDR;
            instr_q    <= 16'h0000;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic fault_q;

    // Sticky: FAULT is only left through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == S_FAULT);
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign mem_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_chip8_fetch.sv
// Testbench for chip8_fetch: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level reference model with a byte-array program memory.
module tb_chip8_fetch;

    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, instr_ready, pc_load, pc_skip;
    logic [AW-1:0] pc_load_val;
    logic [15:0]   mem_rdata = 16'h0000;
    logic [AW-1:0] mem_addr, instr_pc;
    logic [15:0]   instr;
    logic          instr_valid, fault;

    logic [7:0]    mem [0:4095];

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    chip8_fetch #(.ADDR_W(AW), .START_ADDR(12'h200)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .pc_skip(pc_skip), .fault(fault)
    );

    // Big-endian program memory with one cycle of read latency.
    always @(posedge clk) mem_rdata <= {mem[mem_addr], mem[mem_addr + 12'd1]};

    function automatic logic [15:0] rd(input logic [AW-1:0] a);
        return {mem[a], mem[a + 12'd1]};
    endfunction

    // Reference model: next-fetch address, presented opcode, and cycles left in the current read.
    logic [AW-1:0] m_pc    = 12'h200;
    logic [AW-1:0] m_ipc   = '0;
    logic [15:0]   m_instr = 16'h0000;
    logic          m_valid = 1'b0;
    logic          m_fault = 1'b0;
    int            m_left  = 0;

    task automatic m_start();
        m_left = 2;
`ifdef FETCH_ALIGN_CHK_EN
        if (m_pc[0]) begin
            m_fault = 1'b1;
            m_left  = 0;
        end
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 12'h200; m_ipc = '0; m_instr = 16'h0000;
            m_valid = 1'b0; m_fault = 1'b0; m_left = 0;
        end else if (m_fault) begin
            m_left = 0;
        end else if (pc_load) begin
            m_pc    = pc_load_val;
            m_valid = 1'b0;
            m_left  = 0;
            if (run) m_start();
        end else if (m_left == 2) begin
            m_left = 1;
        end else if (m_left == 1) begin
            m_instr = rd(m_pc);
            m_ipc   = m_pc;
            m_pc    = m_pc + 12'd2;
            m_valid = 1'b1;
            m_left  = 0;
        end else if (m_valid) begin
            if (instr_ready) begin
                m_valid = 1'b0;
                if (pc_skip) m_pc = m_pc + 12'd2;
                if (run) m_start();
            end
        end else if (run) begin
            m_start();
        end
    end

    task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (ok) npass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        nchk++;
        if (mem_addr === m_pc && instr_valid === m_valid && fault === m_fault &&
            instr === m_instr && instr_pc === m_ipc) begin
            npass++;
        end else begin
            $display("FAIL model t=%0t actual addr=%h v=%b i=%h ipc=%h f=%b required addr=%h v=%b i=%h ipc=%h f=%b",
                     $time, mem_addr, instr_valid, instr, instr_pc, fault,
                     m_pc, m_valid, m_instr, m_ipc, m_fault);
        end
    end

    // Steps at least one cycle, then until instr_valid is seen or the budget expires.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 12);
        chk("wait_valid", instr_valid === 1'b1, 32'(n), 32'd12);
    endtask

    int            n;
    logic [15:0]   hold_i;

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; pc_load = 1'b0;
        pc_skip = 1'b0; pc_load_val = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
        mem[12'h202] = 8'hA5; mem[12'h203] = 8'h6B;

        repeat (2) @(negedge clk);
        chk("reset_addr",  mem_addr === 12'h200, 32'(mem_addr), 32'h200);
        chk("reset_state", {instr_valid, fault, instr, instr_pc} === 30'd0,
            32'({instr_valid, fault, instr, instr_pc}), 32'd0);
        rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1;

        // Two back-to-back opcodes, three cycles apart
        wait_valid(n);
        chk("t1_lat0", n == 3, 32'(n), 32'd3);
        chk("t1_op0",  {instr, instr_pc} === {16'h1234, 12'h200}, 32'({instr, instr_pc}), 32'h1234200);
        wait_valid(n);
        chk("t1_lat1", n == 3, 32'(n), 32'd3);
        chk("t1_op1",  {instr, instr_pc} === {16'hA56B, 12'h202}, 32'({instr, instr_pc}), 32'hA56B202);
        instr_ready = 1'b0;

        // Stall in VALID
        hold_i = instr;
        repeat (5) begin
            @(negedge clk);
            chk("t2_stall", instr_valid && instr === hold_i && instr_pc === 12'h202 && mem_addr === 12'h204,
                32'({instr_valid, instr, mem_addr}), 32'({1'b1, hold_i, 12'h204}));
        end

        // Skip on transfer
        pc_load = 1'b1; pc_load_val = 12'h300;
        @(negedge clk); pc_load = 1'b0;
        wait_valid(n);
        chk("t3_pc300", instr_pc === 12'h300, 32'(instr_pc), 32'h300);
        instr_ready = 1'b1; pc_skip = 1'b1;
        wait_valid(n);
        chk("t3_pc304", instr_pc === 12'h304, 32'(instr_pc), 32'h304);
        instr_ready = 1'b0; pc_skip = 1'b0;

        // Redirect while capturing
        pc_load = 1'b1; pc_load_val = 12'h100;
        @(negedge clk); pc_load = 1'b0;
        @(negedge clk); pc_load = 1'b1; pc_load_val = 12'h400;
        @(negedge clk); pc_load = 1'b0;
        chk("t4_addr", mem_addr === 12'h400, 32'(mem_addr), 32'h400);
        wait_valid(n);
        chk("t4_pc400", instr_pc === 12'h400 && instr === rd(12'h400), 32'({instr, instr_pc}), 32'({rd(12'h400), 12'h400}));

        // Wrap at top of memory, then asynchronous reset in VALID
        pc_load = 1'b1; pc_load_val = 12'hFFE;
        @(negedge clk); pc_load = 1'b0;
        wait_valid(n);
        chk("t5_pcffe", instr_pc === 12'hFFE, 32'(instr_pc), 32'hFFE);
        instr_ready = 1'b1;
        wait_valid(n);
        chk("t5_wrap", instr_pc === 12'h000, 32'(instr_pc), 32'h000);
        instr_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("t5_rst", instr_valid === 1'b0 && mem_addr === 12'h200,
               32'({instr_valid, mem_addr}), 32'h200);
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            run         = ($urandom_range(0, 7) != 0);
            instr_ready = $urandom_range(0, 1) == 1;
            pc_skip     = $urandom_range(0, 2) == 0;
            pc_load     = $urandom_range(0, 15) == 0;
`ifdef FETCH_ALIGN_CHK_EN
            pc_load_val = {11'($urandom), 1'b0};
`else
            pc_load_val = 12'($urandom);
`endif
        end

        // Odd redirect target
        @(negedge clk);
        run = 1'b0; instr_ready = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        mem[12'h201] = 8'hAB; mem[12'h202] = 8'hCD;
        run = 1'b1; pc_load = 1'b1; pc_load_val = 12'h201;
        @(negedge clk); pc_load = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("t6_fault", fault === 1'b1, 32'(fault), 32'd1);
        repeat (4) begin
            pc_load = 1'b1; pc_load_val = 12'h200; instr_ready = 1'b1;
            @(negedge clk);
            chk("t6_hold", fault === 1'b1 && instr_valid === 1'b0 && mem_addr === 12'h201,
                32'({fault, instr_valid, mem_addr}), 32'({1'b1, 1'b0, 12'h201}));
        end
        pc_load = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_clear", fault === 1'b0, 32'(fault), 32'd0);
        rst_n = 1'b1;
`else
        chk("t6_nofault", fault === 1'b0, 32'(fault), 32'd0);
        wait_valid(n);
        chk("t6_odd", {instr, instr_pc} === {16'hABCD, 12'h201}, 32'({instr, instr_pc}), 32'hABCD201);
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
